// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Queues up to DEPTH commands and then runs them back-to-back against an
// internal accumulator. The accumulator feeds the ALU 'a' operand directly.
// Operand b, function code and carry-in are registered, so the ALU sees
// stable inputs for the whole EXEC cycle. Commands can chain the stored carry
// flag into the next operation. The final accumulator and flags are held on
// the outputs, and a one-cycle done pulse marks the end of a run.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_valid/ready     command write handshake (only accepted in IDLE)
//   cmd_load            1: load cmd_data into acc, no ALU operation
//   cmd_op              ALU function code
//   cmd_cin, cmd_chain  explicit carry-in, or chain the stored carry flag
//   cmd_data            operand B (or load value)
//   start               begin executing the queued commands
//   flush               empty the queue and return to IDLE (acc/flags kept)
//   busy, done          run in progress / one-cycle end-of-run pulse
//   acc_out, flags_out  accumulator and {carry, status[1:0]}
//   alu_a_o..alu_cin_o  ALU operand, function and carry drive
//   alu_y_i..           ALU result, carry/borrow out and status
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int OP_WIDTH   = 5,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_load,
   input  logic [OP_WIDTH-1:0]   cmd_op,
   input  logic                  cmd_cin,
   input  logic                  cmd_chain,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   input  logic                  start,
   input  logic                  flush,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] acc_out,
   output logic [2:0]            flags_out,
   output logic [DATA_WIDTH-1:0] alu_a_o,
   output logic [DATA_WIDTH-1:0] alu_b_o,
   output logic [OP_WIDTH-1:0]   alu_f_o,
   output logic                  alu_cin_o,
   input  logic [DATA_WIDTH-1:0] alu_y_i,
   input  logic                  alu_cout_i,
   input  logic [1:0]            alu_status_i
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int EW = DATA_WIDTH + OP_WIDTH + 3;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_EXEC  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [EW-1:0]         fifo_mem [DEPTH];
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [1:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d;
   logic [2:0]            flags_q, flags_d;
   logic [DATA_WIDTH-1:0] b_q, b_d;
   logic [OP_WIDTH-1:0]   f_q, f_d;
   logic                  cin_q, cin_d;

   logic                  wr_en;
   logic                  pop;
   logic                  head_load;
   logic [OP_WIDTH-1:0]   head_op;
   logic                  head_cin;
   logic                  head_chain;
   logic [DATA_WIDTH-1:0] head_data;

   assign cmd_ready = (state_q == S_IDLE) && (count_q < FULL_COUNT);
   // flush beats a simultaneous write so the queue really ends up empty
   assign wr_en     = cmd_valid && cmd_ready && !flush;

   // Head entry is read combinationally so FETCH can act on it in one cycle
   assign {head_load, head_op, head_cin, head_chain, head_data} = fifo_mem[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         fifo_mem[wr_ptr_q] <= {cmd_load, cmd_op, cmd_cin, cmd_chain, cmd_data};
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      flags_d = flags_q;
      b_d     = b_q;
      f_d     = f_q;
      cin_d   = cin_q;
      pop     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (count_q == '0) begin
               state_d = S_DONE;
            end else if (!flush) begin
               // Entries are discarded by flush, so nothing is popped or applied
               pop = 1'b1;
               if (head_load) begin
                  acc_d   = head_data;
                  flags_d = 3'b000;
               end else begin
                  b_d     = head_data;
                  f_d     = head_op;
                  cin_d   = head_chain ? flags_q[2] : head_cin;
                  state_d = S_EXEC;
               end
            end
         end
         S_EXEC: begin
            // The ALU result is already settled on registered inputs; it is
            // captured even if a flush arrives in this cycle.
            acc_d   = alu_y_i;
            flags_d = {alu_cout_i, alu_status_i};
            state_d = S_FETCH;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (flush) state_d = S_IDLE;
   end

   // Writes happen only in IDLE and pops only in FETCH, so they never collide
   always_comb begin
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         rd_ptr_d = rd_ptr_q + PW'(pop);
         wr_ptr_d = wr_ptr_q + PW'(wr_en);
         count_d  = count_q + CW'(wr_en) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         acc_q    <= '0;
         flags_q  <= '0;
         b_q      <= '0;
         f_q      <= '0;
         cin_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         acc_q    <= acc_d;
         flags_q  <= flags_d;
         b_q      <= b_d;
         f_q      <= f_d;
         cin_q    <= cin_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign acc_out   = acc_q;
   assign flags_out = flags_q;
   assign alu_a_o   = acc_q;
   assign alu_b_o   = b_q;
   assign alu_f_o   = f_q;
   assign alu_cin_o = cin_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
//
// Self-checking bench for alu_cmd_sequencer. An adder stub stands in for the
// ALU (y = a+b+cin, cout = carry, status = {y==0, y[7]}). A queue-based
// reference model replays the accepted commands to predict the accumulator,
// the flags and the start-to-done latency.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_load = 1'b0;
   logic [4:0] cmd_op = '0;
   logic       cmd_cin = 1'b0;
   logic       cmd_chain = 1'b0;
   logic [7:0] cmd_data = '0;
   logic       start = 1'b0;
   logic       flush = 1'b0;
   logic       busy;
   logic       done;
   logic [7:0] acc_out;
   logic [2:0] flags_out;
   logic [7:0] alu_a_o;
   logic [7:0] alu_b_o;
   logic [4:0] alu_f_o;
   logic       alu_cin_o;
   logic [7:0] alu_y_i;
   logic       alu_cout_i;
   logic [1:0] alu_status_i;

   always #5 clk = ~clk;

   // ALU stub
   assign {alu_cout_i, alu_y_i} = {1'b0, alu_a_o} + {1'b0, alu_b_o} + {8'd0, alu_cin_o};
   assign alu_status_i = {alu_y_i == 8'd0, alu_y_i[7]};

   alu_cmd_sequencer #(.DATA_WIDTH(8), .OP_WIDTH(5), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
      .cmd_op(cmd_op), .cmd_cin(cmd_cin), .cmd_chain(cmd_chain), .cmd_data(cmd_data),
      .start(start), .flush(flush), .busy(busy), .done(done),
      .acc_out(acc_out), .flags_out(flags_out),
      .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_f_o(alu_f_o), .alu_cin_o(alu_cin_o),
      .alu_y_i(alu_y_i), .alu_cout_i(alu_cout_i), .alu_status_i(alu_status_i)
   );

   typedef struct {
      bit       load;
      bit       cin;
      bit       chain;
      bit [7:0] data;
   } cmd_t;

   cmd_t     q[$];
   bit [7:0] m_acc;
   bit [2:0] m_flags;
   int       n_vec = 0;
   int       n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Replays the queued commands; returns total cycle cost (load 1, op 2)
   function automatic int model_apply();
      int       cost = 0;
      bit [8:0] s;
      foreach (q[i]) begin
         if (q[i].load) begin
            m_acc   = q[i].data;
            m_flags = 3'b000;
            cost   += 1;
         end else begin
            s       = {1'b0, m_acc} + {1'b0, q[i].data} + 9'(q[i].chain ? m_flags[2] : q[i].cin);
            m_acc   = s[7:0];
            m_flags = {s[8], s[7:0] == 8'd0, s[7]};
            cost   += 2;
         end
      end
      q.delete();
      return cost;
   endfunction

   task automatic push(input bit ld, input bit [7:0] d, input bit ci, input bit ch);
      cmd_t c;
      bit   acc;
      cmd_valid = 1'b1;
      cmd_load  = ld;
      cmd_op    = 5'($urandom_range(0, 31));
      cmd_cin   = ci;
      cmd_chain = ch;
      cmd_data  = d;
      acc       = cmd_ready;
      tick();
      cmd_valid = 1'b0;
      if (acc) begin
         c.load = ld; c.cin = ci; c.chain = ch; c.data = d;
         q.push_back(c);
      end
   endtask

   task automatic run_check(input string tag);
      int cost;
      int lat = -1;
      cost  = model_apply();
      start = 1'b1;
      tick();
      start = 1'b0;
      check_val({tag, "_busy"}, busy, 1);
      check_val({tag, "_ready_busy"}, cmd_ready, 0);
      for (int n = 1; n <= 40; n++) begin
         tick();
         if (done) begin
            lat = n;
            break;
         end
      end
      check_val({tag, "_latency"}, lat, 1 + cost);
      check_val({tag, "_acc"}, acc_out, m_acc);
      check_val({tag, "_flags"}, flags_out, m_flags);
      tick();
      check_val({tag, "_done_once"}, done, 0);
   endtask

   initial begin
      m_acc = '0;
      m_flags = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_val("rst_acc", acc_out, 0);
      check_val("rst_flags", flags_out, 0);
      check_val("rst_b", alu_b_o, 0);
      check_val("rst_f", alu_f_o, 0);
      check_val("rst_cin", alu_cin_o, 0);
      check_val("rst_done", done, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_ready", cmd_ready, 1);

      // 1: load + add
      push(1, 8'h05, 0, 0);
      push(0, 8'h03, 0, 0);
      run_check("t1");
      check_val("t1_acc_const", acc_out, 8'h08);

      // 2: carry chaining
      push(1, 8'hFF, 0, 0);
      push(0, 8'h01, 0, 0);
      push(0, 8'h00, 0, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      check_val("t2_mid_acc", acc_out, 8'h00);
      check_val("t2_mid_flags", flags_out, 3'b110);
      repeat (3) tick();
      check_val("t2_done", done, 1);
      check_val("t2_acc", acc_out, 8'h01);
      check_val("t2_flags", flags_out, 3'b000);
      q.delete();
      m_acc = 8'h01;
      m_flags = 3'b000;
      tick();

      // 3: fill the FIFO, fifth command refused
      for (int i = 0; i < 4; i++) begin
         check_val("t3_ready_fill", cmd_ready, 1);
         push(i == 0, 8'($urandom), 1'($urandom), 1'($urandom));
      end
      check_val("t3_ready_full", cmd_ready, 0);
      push(1, 8'hAA, 0, 0);
      check_val("t3_accepted", q.size(), 4);
      run_check("t3");

      // 5: flush during the second EXEC
      push(1, 8'h10, 0, 0);
      push(0, 8'h01, 0, 0);
      push(0, 8'h02, 0, 0);
      push(0, 8'h03, 0, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check_val("t5_busy", busy, 0);
      check_val("t5_acc", acc_out, 8'h13);
      check_val("t5_flags", flags_out, 3'b000);
      check_val("t5_ready", cmd_ready, 1);
      for (int i = 0; i < 3; i++) begin
         check_val("t5_no_done", done, 0);
         tick();
      end
      q.delete();
      m_acc = 8'h13;
      m_flags = 3'b000;

      // 4: empty run (also proves the flush emptied the queue)
      run_check("t4");
      check_val("t4_acc_const", acc_out, 8'h13);

      // Randomized runs
      for (int r = 0; r < 25; r++) begin
         int k;
         k = $urandom_range(0, 4);
         for (int i = 0; i < k; i++) begin
            push($urandom_range(0, 3) == 0, 8'($urandom), 1'($urandom), 1'($urandom));
         end
         run_check($sformatf("rnd%0d", r));
      end

      // 6: asynchronous reset in the middle of EXEC
      push(1, 8'h42, 0, 0);
      push(0, 8'h11, 1, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (2) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_val("t6_acc", acc_out, 0);
      check_val("t6_flags", flags_out, 0);
      check_val("t6_busy", busy, 0);
      check_val("t6_done", done, 0);
      check_val("t6_ready", cmd_ready, 1);
      check_val("t6_b", alu_b_o, 0);
      check_val("t6_f", alu_f_o, 0);
      check_val("t6_cin", alu_cin_o, 0);
      q.delete();
      m_acc = '0;
      m_flags = '0;
      @(negedge clk);
      rst_n = 1'b1;
      push(1, 8'h05, 0, 0);
      push(0, 8'h03, 0, 0);
      run_check("t6_rerun");
      check_val("t6_rerun_acc_const", acc_out, 8'h08);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
